// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic cells.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SERIAL_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit underflows.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell walks the operands
// LSB-first, with valid/ready handshakes on both the operand and result sides.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             done_valid,
   input  logic             done_ready,
   output logic             busy
);

   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] diff_q;
   logic [WIDTH-1:0] diff_d;
   logic             borrow_q;
   logic [CNT_W-1:0] cnt_q;
   logic             fs_d;
   logic             fs_bout;

   full_subtractor u_fs (
      .a   (a_sh_q[0]),
      .b   (b_sh_q[0]),
      .bin (borrow_q),
      .d   (fs_d),
      .bout(fs_bout)
   );

   // Each new difference bit enters at the MSB so that after WIDTH shifts
   // the first (LSB) bit has reached position 0.
   generate
      if (WIDTH == 1) begin : g_diff_one
         assign diff_d = fs_d;
      end else begin : g_diff_many
         assign diff_d = {fs_d, diff_q[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_valid) begin
                  a_sh_q   <= a;
                  b_sh_q   <= b;
                  borrow_q <= bin;
                  cnt_q    <= '0;
                  diff_q   <= '0;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               diff_q   <= diff_d;
               a_sh_q   <= a_sh_q >> 1;
               b_sh_q   <= b_sh_q >> 1;
               borrow_q <= fs_bout;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (done_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Handshake flags come only from the state register, never from inputs.
   assign start_ready = (state_q == IDLE);
   assign done_valid  = (state_q == DONE);
   assign busy        = (state_q != IDLE);
   assign diff        = diff_q;
   assign bout        = borrow_q;

endmodule
